// File: rtl/pwm_reg_bank.sv
// pwm_reg_bank: register bank behind the I2C frame bridge holding the PWM
// configuration. Duty and period writes go to shadow registers and are copied
// to the active registers together on a period boundary, or right away while
// the PWM is disabled, so a running period never sees a half-updated setting.
// Optional feature macro: PWM_REG_IRQ_EN (commit interrupt flag on irq_o,
// cleared by writing STATUS bit1).
module pwm_reg_bank #(
  parameter int                 NUM_CH       = 16,
  parameter int                 DATA_W       = 16,
  parameter logic [DATA_W-1:0]  PERIOD_RST   = 16'h0FFF,
  parameter logic [DATA_W-1:0]  PRESCALE_RST = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rdata_o,
  input  logic                     period_end_i,
  output logic                     enable_o,
  output logic [DATA_W-1:0]        prescale_o,
  output logic [DATA_W-1:0]        period_o,
  output logic [NUM_CH*DATA_W-1:0] duty_o,
  output logic                     update_pending_o,
  output logic                     irq_o
);

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_PRESCALE   = 8'h01;
  localparam logic [7:0] ADDR_PERIOD     = 8'h02;
  localparam logic [7:0] ADDR_UPDATE     = 8'h03;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_ACT_PERIOD = 8'h30;
  localparam logic [3:0] PAGE_DUTY_SH    = 4'h1;
  localparam logic [3:0] PAGE_DUTY_ACT   = 4'h2;

  logic              ctrl_en_r;
  logic [DATA_W-1:0] prescale_r;
  logic [DATA_W-1:0] period_sh_r;
  logic [DATA_W-1:0] period_act_r;
  logic [DATA_W-1:0] duty_sh_r  [NUM_CH];
  logic [DATA_W-1:0] duty_act_r [NUM_CH];
  logic              pending_r;
  logic [DATA_W-1:0] rdata_r;

  logic [3:0]        duty_idx_s;
  logic              duty_idx_ok_s;
  logic              duty_sh_wr_s;
  logic              update_req_s;
  logic              commit_s;
  logic              pending_next_s;
  logic              irq_flag_s;
  logic [DATA_W-1:0] rd_data_s;

  // Address decode for the duty pages and the commit condition.
  always_comb begin
    duty_idx_s     = addr_i[3:0];
    duty_idx_ok_s  = ({28'd0, duty_idx_s} < 32'(NUM_CH));
    duty_sh_wr_s   = wr_en_i && (addr_i[7:4] == PAGE_DUTY_SH) && duty_idx_ok_s;
    update_req_s   = wr_en_i && (addr_i == ADDR_UPDATE) && wdata_i[0];
    commit_s       = pending_r && (period_end_i || !ctrl_en_r);
    pending_next_s = (pending_r && !commit_s) || update_req_s;
  end

  // Configuration registers and shadow registers written from the bridge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en_r   <= 1'b0;
      prescale_r  <= PRESCALE_RST;
      period_sh_r <= PERIOD_RST;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_r[n] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_en_i && (addr_i == ADDR_CTRL)) begin
        ctrl_en_r <= wdata_i[0];
      end
      if (wr_en_i && (addr_i == ADDR_PRESCALE)) begin
        prescale_r <= wdata_i;
      end
      if (wr_en_i && (addr_i == ADDR_PERIOD)) begin
        period_sh_r <= wdata_i;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (duty_sh_wr_s && ({28'd0, duty_idx_s} == 32'(n))) begin
          duty_sh_r[n] <= wdata_i;
        end
      end
    end
  end

  // Active registers: copy all shadows in one edge when a commit fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_act_r <= PERIOD_RST;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_act_r[n] <= {DATA_W{1'b0}};
      end
    end else if (commit_s) begin
      period_act_r <= period_sh_r;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_act_r[n] <= duty_sh_r[n];
      end
    end
  end

  // Outstanding commit request; a new request in the commit cycle survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

`ifdef PWM_REG_IRQ_EN
  logic irq_r;
  logic irq_clr_s;

  // STATUS write with bit1 set requests a flag clear.
  always_comb begin
    irq_clr_s = wr_en_i && (addr_i == ADDR_STATUS) && wdata_i[1];
  end

  // Commit interrupt flag; a commit in the clear cycle keeps it set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (irq_r && !irq_clr_s) || commit_s;
    end
  end

  assign irq_flag_s = irq_r;
`else
  assign irq_flag_s = 1'b0;
`endif

  // Read mux; reads see register contents from before any same-cycle write.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    case (addr_i)
      ADDR_CTRL:       rd_data_s[0] = ctrl_en_r;
      ADDR_PRESCALE:   rd_data_s    = prescale_r;
      ADDR_PERIOD:     rd_data_s    = period_sh_r;
      ADDR_UPDATE:     rd_data_s[0] = pending_r;
      ADDR_STATUS: begin
        rd_data_s[0] = pending_r;
        rd_data_s[1] = irq_flag_s;
      end
      ADDR_ACT_PERIOD: rd_data_s    = period_act_r;
      default: begin
        if ((addr_i[7:4] == PAGE_DUTY_SH) && duty_idx_ok_s) begin
          rd_data_s = duty_sh_r[duty_idx_s];
        end else if ((addr_i[7:4] == PAGE_DUTY_ACT) && duty_idx_ok_s) begin
          rd_data_s = duty_act_r[duty_idx_s];
        end else begin
          rd_data_s = {DATA_W{1'b0}};
        end
      end
    endcase
  end

  // Read data register, loaded only on a read strobe and held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rdata_r <= rd_data_s;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_duty_out
      assign duty_o[g*DATA_W +: DATA_W] = duty_act_r[g];
    end
  endgenerate

  assign rdata_o          = rdata_r;
  assign enable_o         = ctrl_en_r;
  assign prescale_o       = prescale_r;
  assign period_o         = period_act_r;
  assign update_pending_o = pending_r;
  assign irq_o            = irq_flag_s;

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Directed bench for pwm_reg_bank: read results are queued as expected values
// when the read is issued and compared once rdata_o is valid.
module tb_pwm_reg_bank;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 16;

`ifdef PWM_REG_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic [7:0]               addr_i = 8'h00;
  logic [DATA_W-1:0]        wdata_i = 16'h0000;
  logic                     wr_en_i = 1'b0;
  logic                     rd_en_i = 1'b0;
  logic [DATA_W-1:0]        rdata_o;
  logic                     period_end_i = 1'b0;
  logic                     enable_o;
  logic [DATA_W-1:0]        prescale_o;
  logic [DATA_W-1:0]        period_o;
  logic [NUM_CH*DATA_W-1:0] duty_o;
  logic                     update_pending_o;
  logic                     irq_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  pwm_reg_bank #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .PERIOD_RST(16'h0FFF),
    .PRESCALE_RST(16'h0000)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .wr_en_i(wr_en_i),
    .rd_en_i(rd_en_i),
    .rdata_o(rdata_o),
    .period_end_i(period_end_i),
    .enable_o(enable_o),
    .prescale_o(prescale_o),
    .period_o(period_o),
    .duty_o(duty_o),
    .update_pending_o(update_pending_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    addr_i  = a;
    wdata_i = d;
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] e;
    addr_i  = a;
    rd_en_i = 1'b1;
    exp_q.push_back(exp);
    tick();
    rd_en_i = 1'b0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'h0000, rdata_o}, {16'h0000, e});
    end
  endtask

  function automatic logic [15:0] ch(input int n);
    return duty_o[n*DATA_W +: DATA_W];
  endfunction

  initial begin
    // Reset state
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_period", {16'h0, period_o}, 32'h0FFF);
    check("rst_duty_any", {31'h0, |duty_o}, 32'h0);
    check("rst_enable", {31'h0, enable_o}, 32'h0);
    check("rst_rdata", {16'h0, rdata_o}, 32'h0);
    check("rst_pending", {31'h0, update_pending_o}, 32'h0);
    check("rst_prescale", {16'h0, prescale_o}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    do_read("rd_act_period_rst", 8'h30, 16'h0FFF);
    do_read("rd_period_sh_rst", 8'h02, 16'h0FFF);

    // Enable, shadow write without UPDATE
    do_write(8'h00, 16'hFFFF);
    check("en_set", {31'h0, enable_o}, 32'h1);
    do_read("rd_ctrl", 8'h00, 16'h0001);
    do_write(8'h13, 16'h0800);
    check("ch3_no_update", {16'h0, ch(3)}, 32'h0);
    do_read("rd_duty3_sh", 8'h13, 16'h0800);
    tick();
    tick();
    check("rdata_hold", {16'h0, rdata_o}, 32'h0800);
    do_read("rd_duty3_act", 8'h23, 16'h0000);

    // UPDATE waits for period end while enabled
    do_write(8'h03, 16'h0001);
    check("pend_set", {31'h0, update_pending_o}, 32'h1);
    tick();
    tick();
    check("ch3_wait", {16'h0, ch(3)}, 32'h0);
    do_read("rd_update", 8'h03, 16'h0001);
    do_read("rd_status_pend", 8'h04, 16'h0001);
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("ch3_commit", {16'h0, ch(3)}, 32'h0800);
    check("pend_clr", {31'h0, update_pending_o}, 32'h0);
    check("irq_after_commit", {31'h0, irq_o}, {31'h0, IRQ_ON});

    // Shadow write in the commit cycle: active takes the old shadow
    do_write(8'h13, 16'h0200);
    do_write(8'h03, 16'h0001);
    addr_i = 8'h13;
    wdata_i = 16'h0100;
    wr_en_i = 1'b1;
    period_end_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    period_end_i = 1'b0;
    check("ch3_old_shadow", {16'h0, ch(3)}, 32'h0200);
    check("pend_clr2", {31'h0, update_pending_o}, 32'h0);
    do_read("rd_duty3_sh_new", 8'h13, 16'h0100);
    do_read("rd_duty3_act_old", 8'h23, 16'h0200);

    // period_end without pending does nothing
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("ch3_no_pend", {16'h0, ch(3)}, 32'h0200);

    // UPDATE in the commit cycle keeps pending set
    do_write(8'h03, 16'h0001);
    addr_i = 8'h03;
    wdata_i = 16'h0001;
    wr_en_i = 1'b1;
    period_end_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    period_end_i = 1'b0;
    check("ch3_commit2", {16'h0, ch(3)}, 32'h0100);
    check("pend_kept", {31'h0, update_pending_o}, 32'h1);
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("pend_clr3", {31'h0, update_pending_o}, 32'h0);

    // Disabled: commit the cycle after UPDATE
    do_write(8'h00, 16'h0000);
    check("en_clr", {31'h0, enable_o}, 32'h0);
    do_write(8'h02, 16'h00FF);
    check("period_unchanged", {16'h0, period_o}, 32'h0FFF);
    do_write(8'h03, 16'h0001);
    check("period_pre_commit", {16'h0, period_o}, 32'h0FFF);
    tick();
    check("period_commit_dis", {16'h0, period_o}, 32'h00FF);
    check("pend_clr_dis", {31'h0, update_pending_o}, 32'h0);

    // Prescale, RO write, unmapped reads, read-before-write
    do_write(8'h01, 16'h1234);
    check("prescale", {16'h0, prescale_o}, 32'h1234);
    do_write(8'h30, 16'h1111);
    do_read("rd_act_period_ro", 8'h30, 16'h00FF);
    do_write(8'h23, 16'h7777);
    do_read("rd_duty3_act_ro", 8'h23, 16'h0100);
    do_read("rd_unmapped_05", 8'h05, 16'h0000);
    do_read("rd_unmapped_40", 8'h40, 16'h0000);
    addr_i = 8'h01;
    wdata_i = 16'h5555;
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    exp_q.push_back(16'h1234);
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    check("rdwr_same_addr", {16'h0, rdata_o}, {16'h0, exp_q.pop_front()});
    check("prescale_new", {16'h0, prescale_o}, 32'h5555);

    // Interrupt flag status and clear
    do_read("rd_status_irq", 8'h04, IRQ_ON ? 16'h0002 : 16'h0000);
    do_write(8'h04, 16'h0002);
    check("irq_cleared", {31'h0, irq_o}, 32'h0);
    do_write(8'h03, 16'h0001);
    do_write(8'h04, 16'h0002);
    check("irq_set_wins", {31'h0, irq_o}, {31'h0, IRQ_ON});
    do_write(8'h04, 16'h0002);
    check("irq_cleared2", {31'h0, irq_o}, 32'h0);

    // Reset discards a pending commit
    do_write(8'h00, 16'h0001);
    do_write(8'h15, 16'h0777);
    do_write(8'h03, 16'h0001);
    check("pend_before_rst", {31'h0, update_pending_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    check("rst_mid_pend", {31'h0, update_pending_o}, 32'h0);
    check("rst_mid_ch5", {16'h0, ch(5)}, 32'h0);
    check("rst_mid_period", {16'h0, period_o}, 32'h0FFF);
    do_read("rd_duty5_after_rst", 8'h15, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
